sequencer: RTL
==============

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter WORD_W, default 8, data/address word width of the attached datapath.
REQ-002 Parameter OP_W, default 3, opcode field width taken from the instruction register.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset sampled on the rising edge of clock.
REQ-005 op  input  OP_W  opcode field of the instruction register.
REQ-006 z_flag  input  1  accumulator-zero flag from the ALU.
REQ-007 mem_ready  input  1  memory handshake; high means the current access completes this cycle.
REQ-008 ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor  output  1 each  ALU/accumulator controls.
REQ-009 PC_bus, load_PC, INC_PC, Addr_bus, load_IR, load_MAR, MDR_bus, load_MDR  output  1 each  datapath bus and load controls.
REQ-010 CS, R_NW  output  1 each  memory chip select; read (1) / write (0).
REQ-011 halted  output  1  high while the sequencer is in the HALT state.

Function
REQ-012 States SHALL be: FETCH, MREAD_I, LOAD_IR, DECODE, WR_MDR, MWRITE, MREAD_D, EXEC, HALT.
REQ-013 Opcodes SHALL be: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 XOR, 101 BNE, 110 BEQ, 111 HALT.
REQ-014 FETCH SHALL assert PC_bus, load_MAR, INC_PC and load_PC, then go to MREAD_I.
REQ-015 MREAD_I SHALL assert CS and R_NW; it SHALL stay in MREAD_I while mem_ready=0 and go to LOAD_IR when mem_ready=1.
REQ-016 LOAD_IR SHALL assert MDR_bus and load_IR, then go to DECODE.
REQ-017 DECODE, for LOAD/ADD/SUB/XOR, SHALL assert Addr_bus and load_MAR and go to MREAD_D.
REQ-018 DECODE, for STORE, SHALL assert Addr_bus and load_MAR and go to WR_MDR.
REQ-019 DECODE, for BNE with z_flag=0 or BEQ with z_flag=1, SHALL assert Addr_bus and load_PC; for any branch it SHALL go to FETCH.
REQ-020 DECODE, for HALT, SHALL assert nothing and go to HALT.
REQ-021 WR_MDR SHALL assert ACC_bus and load_MDR, then go to MWRITE.
REQ-022 MWRITE SHALL assert CS with R_NW=0, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-023 MREAD_D SHALL assert CS and R_NW, hold while mem_ready=0, and go to EXEC when mem_ready=1.
REQ-024 EXEC SHALL assert MDR_bus and load_ACC, then go to FETCH.
REQ-025 EXEC SHALL additionally assert ALU_ACC plus exactly one of ALU_add/ALU_sub/ALU_xor for ADD/SUB/XOR, and no ALU_* signal for LOAD.
REQ-026 HALT SHALL assert halted only and remain in HALT until reset.
REQ-027 Every output not listed for a state SHALL be 0 in that state.
REQ-028 At most one bus driver (ACC_bus, PC_bus, Addr_bus, MDR_bus) SHALL be high in any cycle.
REQ-029 Outputs SHALL be combinational from state, with op and z_flag also used in DECODE/EXEC only; next state is registered.
REQ-030 With mem_ready held at 1, latency SHALL be 6 cycles for LOAD/ADD/SUB/XOR/STORE and 4 cycles for branches; each mem_ready=0 cycle adds one cycle.

Reset
REQ-031 reset=1 at a rising edge SHALL force the state to FETCH from any state, including mid memory wait or HALT.
REQ-032 While reset=1, all outputs SHALL be forced to 0.
REQ-033 The first cycle after reset deasserts SHALL present FETCH outputs.

Structure
REQ-034 Package cpu_defs_pkg SHALL hold the opcode enum (OP_W bits), the state enum and the WORD_W/OP_W defaults.
REQ-035 The state enum SHALL be shared with the datapath bench for state-name tracing.
REQ-036 The block SHALL be a single module with no sub-module; the instruction decode is an internal combinational block.

Verification
REQ-037 ADD (op=010), mem_ready=1 -> states FETCH,MREAD_I,LOAD_IR,DECODE,MREAD_D,EXEC; in EXEC, load_ACC=ALU_ACC=ALU_add=1; 6 cycles.
REQ-038 STORE (op=001), mem_ready low 3 cycles in MWRITE -> CS=1/R_NW=0 held 4 cycles; ACC_bus=load_MDR=1 in WR_MDR; return to FETCH.
REQ-039 BNE (op=101): z_flag=0 -> load_PC=Addr_bus=1 in DECODE; z_flag=1 -> load_PC=0; FETCH follows after 4 cycles in both cases.
REQ-040 HALT (op=111) -> halted=1 held 20 cycles, all other outputs 0; reset pulse -> FETCH next cycle.
REQ-041 reset asserted while in MREAD_D with mem_ready=0 -> all outputs 0 that cycle and FETCH after release.
REQ-042 Random op/z_flag/mem_ready for 10k cycles -> bus-driver one-hot-or-zero assertion never fails.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs_pkg
//  Description : Shared opcode/state encodings and default widths for the
//                accumulator CPU sequencer and its datapath bench.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int WORD_W_DEFAULT = 8;
    localparam int OP_W_DEFAULT   = 3;

    typedef enum logic [OP_W_DEFAULT-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_XOR   = 3'b100,
        OP_BNE   = 3'b101,
        OP_BEQ   = 3'b110,
        OP_HALT  = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        MREAD_I = 4'd1,
        LOAD_IR = 4'd2,
        DECODE  = 4'd3,
        WR_MDR  = 4'd4,
        MWRITE  = 4'd5,
        MREAD_D = 4'd6,
        EXEC    = 4'd7,
        HALT    = 4'd8
    } state_e;

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sequencer
//  Description : Control FSM for a single-accumulator CPU; Moore outputs per
//                state, with opcode/zero-flag qualifying DECODE and EXEC.
//  Revision    : 1.0  initial release
// ============================================================================
module sequencer
    import cpu_defs_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int OP_W   = OP_W_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    // The decode table is written for the 3-bit opcode set only.
    if (OP_W != OP_W_DEFAULT || WORD_W < 1) begin : g_param_check
        $error("sequencer: OP_W must be %0d and WORD_W positive", OP_W_DEFAULT);
    end

    state_e r_state;
    state_e w_state_next;
    op_e    w_op;

    assign w_op = op_e'(op);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ACC_bus      = 1'b0;
        load_ACC     = 1'b0;
        ALU_ACC      = 1'b0;
        ALU_add      = 1'b0;
        ALU_sub      = 1'b0;
        ALU_xor      = 1'b0;
        PC_bus       = 1'b0;
        load_PC      = 1'b0;
        INC_PC       = 1'b0;
        Addr_bus     = 1'b0;
        load_IR      = 1'b0;
        load_MAR     = 1'b0;
        MDR_bus      = 1'b0;
        load_MDR     = 1'b0;
        CS           = 1'b0;
        R_NW         = 1'b0;
        halted       = 1'b0;

        case (r_state)
            FETCH: begin
                PC_bus       = 1'b1;
                load_MAR     = 1'b1;
                INC_PC       = 1'b1;
                load_PC      = 1'b1;
                w_state_next = MREAD_I;
            end
            MREAD_I: begin
                CS   = 1'b1;
                R_NW = 1'b1;
                if (mem_ready) w_state_next = LOAD_IR;
            end
            LOAD_IR: begin
                MDR_bus      = 1'b1;
                load_IR      = 1'b1;
                w_state_next = DECODE;
            end
            DECODE: begin
                case (w_op)
                    OP_LOAD, OP_ADD, OP_SUB, OP_XOR: begin
                        Addr_bus     = 1'b1;
                        load_MAR     = 1'b1;
                        w_state_next = MREAD_D;
                    end
                    OP_STORE: begin
                        Addr_bus     = 1'b1;
                        load_MAR     = 1'b1;
                        w_state_next = WR_MDR;
                    end
                    OP_BNE, OP_BEQ: begin
                        // Taken branch loads the operand address into PC.
                        if ((w_op == OP_BNE) != z_flag) begin
                            Addr_bus = 1'b1;
                            load_PC  = 1'b1;
                        end
                        w_state_next = FETCH;
                    end
                    default: w_state_next = HALT;
                endcase
            end
            WR_MDR: begin
                ACC_bus      = 1'b1;
                load_MDR     = 1'b1;
                w_state_next = MWRITE;
            end
            MWRITE: begin
                CS = 1'b1;
                if (mem_ready) w_state_next = FETCH;
            end
            MREAD_D: begin
                CS   = 1'b1;
                R_NW = 1'b1;
                if (mem_ready) w_state_next = EXEC;
            end
            EXEC: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                case (w_op)
                    OP_ADD: begin
                        ALU_ACC = 1'b1;
                        ALU_add = 1'b1;
                    end
                    OP_SUB: begin
                        ALU_ACC = 1'b1;
                        ALU_sub = 1'b1;
                    end
                    OP_XOR: begin
                        ALU_ACC = 1'b1;
                        ALU_xor = 1'b1;
                    end
                    default: ;
                endcase
                w_state_next = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: w_state_next = FETCH;
        endcase

        // Reset silences every control line in the same cycle it is applied.
        if (reset) begin
            ACC_bus  = 1'b0;
            load_ACC = 1'b0;
            ALU_ACC  = 1'b0;
            ALU_add  = 1'b0;
            ALU_sub  = 1'b0;
            ALU_xor  = 1'b0;
            PC_bus   = 1'b0;
            load_PC  = 1'b0;
            INC_PC   = 1'b0;
            Addr_bus = 1'b0;
            load_IR  = 1'b0;
            load_MAR = 1'b0;
            MDR_bus  = 1'b0;
            load_MDR = 1'b0;
            CS       = 1'b0;
            R_NW     = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule : sequencer
`default_nettype wire
